alu_axil_slave: RTL

ALU_AXIL_SLAVE -- requirements
Module: alu_axil_slave

---
 rtl/alu_axil_slave_if.sv | 44 ++++
 rtl/alu_axil_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_axil_slave_if.sv
//==============================================================================
// alu_axil_slave_if : AXI4-Lite bus bundle for the alu_axil_slave register block
// Rev 1.0
//==============================================================================
`default_nettype none

interface alu_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

`default_nettype wire

// File: rtl/alu_axil_slave.sv
//==============================================================================
// alu_axil_slave : AXI4-Lite slave with a two-cycle ALU (MUL opcode via ALU_AXIL_MUL_EN)
// Rev 1.0
//==============================================================================
`default_nettype none

module alu_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  wire logic        ACLK,
  input  wire logic        ARESET,
  alu_axil_slave_if.slave  s_axi,
  output logic             irq
);
  localparam int         c_DW          = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] c_IDLE        = 2'd0;
  localparam logic [1:0] c_EXEC        = 2'd1;
  localparam logic [1:0] c_DONE        = 2'd2;
  localparam logic [1:0] c_REG_OPA     = 2'd0;
  localparam logic [1:0] c_REG_OPB     = 2'd1;
  localparam logic [1:0] c_REG_CTRL    = 2'd2;
  localparam logic [1:0] c_REG_RESULT  = 2'd3;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  function automatic logic [c_DW-1:0] f_merge(input logic [c_DW-1:0]   old_v,
                                               input logic [c_DW-1:0]   new_v,
                                               input logic [c_DW/8-1:0] strb);
    logic [c_DW-1:0] v;
    v = old_v;
    for (int i = 0; i < c_DW/8; i++) begin
      if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
    end
    return v;
  endfunction

  logic              r_awready, r_wready, r_aw_latched, r_w_latched;
  logic [1:0]        r_awaddr;
  logic [c_DW-1:0]   r_wdata;
  logic [c_DW/8-1:0] r_wstrb;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_arready, r_rvalid;
  logic [c_DW-1:0]   r_rdata;
  logic [c_DW-1:0]   r_opa, r_opb, r_result;
  logic [3:0]        r_opcode;
  logic              r_done, r_err;
  logic [1:0]        r_state;
  logic [c_DW-1:0]   r_lat_a, r_lat_b;
  logic [3:0]        r_lat_op;

  logic              w_do_write, w_busy, w_wr_ctrl, w_start_req, w_start, w_clr;
  logic [3:0]        w_opcode_next;
  logic [1:0]        w_bresp;
  logic [c_DW-1:0]   w_ctrl_rd, w_rd_mux, w_alu_res;
  logic              w_alu_err;
  logic              w_unused;

  // A write commits exactly once: after both halves are latched and before its response is taken.
  assign w_do_write    = r_aw_latched & r_w_latched & ~r_bvalid;
  assign w_busy        = (r_state != c_IDLE);
  assign w_wr_ctrl     = w_do_write & (r_awaddr == c_REG_CTRL);
  assign w_start_req   = w_wr_ctrl & r_wstrb[1] & r_wdata[8];
  assign w_start       = w_start_req & ~w_busy;
  assign w_clr         = w_wr_ctrl & r_wstrb[1] & r_wdata[9];
  assign w_opcode_next = r_wstrb[0] ? r_wdata[3:0] : r_opcode;
  assign w_bresp       = ((r_awaddr == c_REG_RESULT) || (w_start_req && w_busy)) ?
                         c_RESP_SLVERR : c_RESP_OKAY;
  assign w_ctrl_rd     = {13'd0, r_err, r_done, w_busy, 12'd0, r_opcode};
  assign w_unused      = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = c_RESP_OKAY;
  assign irq                 = r_done;

  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (r_lat_op)
      4'd0: w_alu_res = r_lat_a + r_lat_b;
      4'd1: w_alu_res = r_lat_a - r_lat_b;
      4'd2: w_alu_res = r_lat_a & r_lat_b;
      4'd3: w_alu_res = r_lat_a | r_lat_b;
      4'd4: w_alu_res = r_lat_a ^ r_lat_b;
      4'd5: w_alu_res = r_lat_a << r_lat_b[4:0];
      4'd6: w_alu_res = r_lat_a >> r_lat_b[4:0];
      4'd7: w_alu_res = {{(c_DW-1){1'b0}}, ($signed(r_lat_a) < $signed(r_lat_b))};
`ifdef ALU_AXIL_MUL_EN
      4'd8: w_alu_res = r_lat_a * r_lat_b;
`endif
      default: w_alu_err = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2])
      c_REG_OPA:  w_rd_mux = r_opa;
      c_REG_OPB:  w_rd_mux = r_opb;
      c_REG_CTRL: w_rd_mux = w_ctrl_rd;
      default:    w_rd_mux = r_result;
    endcase
  end

  // Write address/data capture and response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= c_RESP_OKAY;
    end else begin
      r_awready <= s_axi.S_AXI_AWVALID & ~r_aw_latched & ~r_bvalid & ~r_awready;
      r_wready  <= s_axi.S_AXI_WVALID  & ~r_w_latched  & ~r_bvalid & ~r_wready;
      if (r_awready && s_axi.S_AXI_AWVALID) begin
        r_aw_latched <= 1'b1;
        r_awaddr     <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (r_wready && s_axi.S_AXI_WVALID) begin
        r_w_latched <= 1'b1;
        r_wdata     <= s_axi.S_AXI_WDATA;
        r_wstrb     <= s_axi.S_AXI_WSTRB;
      end
      if (w_do_write) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp;
      end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
        r_bvalid     <= 1'b0;
        r_aw_latched <= 1'b0;
        r_w_latched  <= 1'b0;
      end
    end
  end

  // Register file, compute FSM and status flags
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_state  <= c_IDLE;
      r_lat_a  <= '0;
      r_lat_b  <= '0;
      r_lat_op <= '0;
    end else begin
      if (w_do_write) begin
        case (r_awaddr)
          c_REG_OPA:  r_opa    <= f_merge(r_opa, r_wdata, r_wstrb);
          c_REG_OPB:  r_opb    <= f_merge(r_opb, r_wdata, r_wstrb);
          c_REG_CTRL: r_opcode <= w_opcode_next;
          default:    ;
        endcase
      end
      case (r_state)
        c_IDLE: if (w_start) begin
          r_state  <= c_EXEC;
          r_lat_a  <= r_opa;
          r_lat_b  <= r_opb;
          r_lat_op <= w_opcode_next;
        end
        c_EXEC:  r_state <= c_DONE;
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
      // Completion takes priority over a coincident clr_done.
      if (r_state == c_DONE) begin
        r_result <= w_alu_res;
        r_done   <= 1'b1;
        r_err    <= w_alu_err;
      end else if (w_start || w_clr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

  // Read channel: data is captured at the address handshake, so it reflects pre-update state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (r_arready && s_axi.S_AXI_ARVALID) begin
        r_rdata  <= w_rd_mux;
        r_rvalid <= 1'b1;
      end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire
